// File: rtl/exec_unit_pipe.sv
`default_nettype none
// ============================================================================
// exec_unit_pipe : EX stage with operand forwarding, single-cycle ALU and an
// optional radix-2 serial multiplier (compiled in by EXEC_UNIT_MUL_EN).
// Revision: 1.0
// ============================================================================
module exec_unit_pipe #(
   parameter int XLEN      = 32,
   parameter int FWD_EN_WB = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] rdata1,
   input  logic [XLEN-1:0] rdata2,
   input  logic [XLEN-1:0] imm,
   input  logic            alu_src,
   input  logic [3:0]      alu_op,
   input  logic            wb_en,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic [4:0]      exmem_rd,
   input  logic            exmem_wb,
   input  logic [XLEN-1:0] exmem_res,
   input  logic [4:0]      memwb_rd,
   input  logic            memwb_wb,
   input  logic [XLEN-1:0] memwb_res,
   output logic            out_valid,
   output logic [XLEN-1:0] out_res,
   output logic [XLEN-1:0] out_store,
   output logic [4:0]      out_rd,
   output logic            out_wb,
   output logic            out_mem_rd,
   output logic            out_mem_wr
);

   localparam int SW = $clog2(XLEN);

   logic [XLEN-1:0] fwd1;
   logic [XLEN-1:0] fwd2;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [SW-1:0]   shamt;
   logic [XLEN-1:0] alu_res;
   logic            issue;

   logic            done;
   logic [XLEN-1:0] done_res;
   logic [XLEN-1:0] done_store;
   logic [4:0]      done_rd;
   logic            done_wb;
   logic            done_mem_rd;
   logic            done_mem_wr;

   // EX/MEM has priority over MEM/WB; x0 is never forwarded.
   function automatic logic [XLEN-1:0] forward(input logic [4:0] rs, input logic [XLEN-1:0] rf);
      logic [XLEN-1:0] val;
      val = rf;
      if (rs != 5'd0) begin
         if (exmem_wb && (exmem_rd == rs))
            val = exmem_res;
         else if ((FWD_EN_WB != 0) && memwb_wb && (memwb_rd == rs))
            val = memwb_res;
      end
      return val;
   endfunction

   assign fwd1  = forward(rs1, rdata1);
   assign fwd2  = forward(rs2, rdata2);
   assign op_a  = fwd1;
   assign op_b  = alu_src ? imm : fwd2;
   assign shamt = op_b[SW-1:0];
   assign issue = in_valid && in_ready && !flush;

   always_comb begin
      alu_res = '0;
      case (alu_op)
         4'd0:    alu_res = op_a + op_b;
         4'd1:    alu_res = op_a - op_b;
         4'd2:    alu_res = op_a & op_b;
         4'd3:    alu_res = op_a | op_b;
         4'd4:    alu_res = op_a ^ op_b;
         4'd5:    alu_res = op_a << shamt;
         4'd6:    alu_res = op_a >> shamt;
         4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
         4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'd9:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         default: alu_res = '0;
      endcase
   end

`ifdef EXEC_UNIT_MUL_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [SW-1:0]     cnt;
   logic [2*XLEN-1:0] acc;
   logic [2*XLEN-1:0] mcand;
   logic [XLEN-1:0]   mplr;
   logic              mul_hi;
   logic              is_mul;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   pend_store;
   logic [4:0]        pend_rd;
   logic              pend_wb;
   logic              pend_mem_rd;
   logic              pend_mem_wr;

   assign in_ready = (state == IDLE);
   assign is_mul   = (alu_op == 4'd10) || (alu_op == 4'd11);
   assign mul_res  = mul_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue && is_mul) state_nxt = MUL;
         MUL:     if (cnt == SW'(XLEN-1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Shift-add: multiplicand moves left, multiplier moves right, one bit per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         acc         <= '0;
         mcand       <= '0;
         mplr        <= '0;
         mul_hi      <= 1'b0;
         pend_store  <= '0;
         pend_rd     <= '0;
         pend_wb     <= 1'b0;
         pend_mem_rd <= 1'b0;
         pend_mem_wr <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
         acc <= '0;
      end else if (issue && is_mul) begin
         cnt         <= '0;
         acc         <= '0;
         mcand       <= {{XLEN{1'b0}}, op_a};
         mplr        <= op_b;
         mul_hi      <= alu_op[0];
         pend_store  <= fwd2;
         pend_rd     <= rd;
         pend_wb     <= wb_en;
         pend_mem_rd <= mem_rd;
         pend_mem_wr <= mem_wr;
      end else if (state == MUL) begin
         if (mplr[0])
            acc <= acc + mcand;
         mcand <= mcand << 1;
         mplr  <= mplr >> 1;
         cnt   <= (cnt == SW'(XLEN-1)) ? '0 : cnt + 1'b1;
      end
   end

   assign done        = (issue && !is_mul) || ((state == DONE) && !flush);
   assign done_res    = (state == DONE) ? mul_res     : alu_res;
   assign done_store  = (state == DONE) ? pend_store  : fwd2;
   assign done_rd     = (state == DONE) ? pend_rd     : rd;
   assign done_wb     = (state == DONE) ? pend_wb     : wb_en;
   assign done_mem_rd = (state == DONE) ? pend_mem_rd : mem_rd;
   assign done_mem_wr = (state == DONE) ? pend_mem_wr : mem_wr;
`else
   assign in_ready    = 1'b1;
   assign done        = issue;
   assign done_res    = alu_res;
   assign done_store  = fwd2;
   assign done_rd     = rd;
   assign done_wb     = wb_en;
   assign done_mem_rd = mem_rd;
   assign done_mem_wr = mem_wr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_res    <= '0;
         out_store  <= '0;
         out_rd     <= '0;
         out_wb     <= 1'b0;
         out_mem_rd <= 1'b0;
         out_mem_wr <= 1'b0;
      end else begin
         out_valid <= done;
         if (done) begin
            out_res    <= done_res;
            out_store  <= done_store;
            out_rd     <= done_rd;
            out_wb     <= done_wb;
            out_mem_rd <= done_mem_rd;
            out_mem_wr <= done_mem_wr;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_pipe.sv
`default_nettype none
// tb_exec_unit_pipe : directed and randomized checks of exec_unit_pipe
// against an arithmetic reference model (multiplier tests with EXEC_UNIT_MUL_EN).
module tb_exec_unit_pipe;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid, in_ready, flush;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rdata1, rdata2, imm;
   logic            alu_src;
   logic [3:0]      alu_op;
   logic            wb_en, mem_rd, mem_wr;
   logic [4:0]      exmem_rd, memwb_rd;
   logic            exmem_wb, memwb_wb;
   logic [XLEN-1:0] exmem_res, memwb_res;
   logic            out_valid;
   logic [XLEN-1:0] out_res, out_store;
   logic [4:0]      out_rd;
   logic            out_wb, out_mem_rd, out_mem_wr;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] e_res = '0;
   logic [XLEN-1:0] e_store = '0;
   logic [4:0]      e_rd = '0;
   logic            e_wb = 1'b0, e_mrd = 1'b0, e_mwr = 1'b0;

   always #5 clk = ~clk;

   exec_unit_pipe #(.XLEN(XLEN), .FWD_EN_WB(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .rs1(rs1), .rs2(rs2), .rd(rd), .rdata1(rdata1), .rdata2(rdata2), .imm(imm),
      .alu_src(alu_src), .alu_op(alu_op), .wb_en(wb_en), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .exmem_rd(exmem_rd), .exmem_wb(exmem_wb), .exmem_res(exmem_res),
      .memwb_rd(memwb_rd), .memwb_wb(memwb_wb), .memwb_res(memwb_res),
      .out_valid(out_valid), .out_res(out_res), .out_store(out_store), .out_rd(out_rd),
      .out_wb(out_wb), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr)
   );

   function automatic logic [XLEN-1:0] fwd_model(input logic [4:0] rs, input logic [XLEN-1:0] rf);
      if (rs == 5'd0) return rf;
      if (exmem_wb && exmem_rd == rs) return exmem_res;
      if (memwb_wb && memwb_rd == rs) return memwb_res;
      return rf;
   endfunction

   function automatic logic [XLEN-1:0] alu_model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      longint          sa = 64'($signed(a));
      longint          sb = 64'($signed(b));
      int              sh = int'(b[4:0]);
      case (op)
         4'd0: return 32'(ua + ub);
         4'd1: return 32'(ua - ub);
         4'd2: return 32'(ua & ub);
         4'd3: return 32'(ua | ub);
         4'd4: return 32'(ua ^ ub);
         4'd5: return 32'(ua << sh);
         4'd6: return 32'(ua >> sh);
         4'd7: return 32'(sa >>> sh);
         4'd8: return (sa < sb) ? 32'd1 : 32'd0;
         4'd9: return (ua < ub) ? 32'd1 : 32'd0;
`ifdef EXEC_UNIT_MUL_EN
         4'd10: return 32'(ua * ub);
         4'd11: return 32'((ua * ub) >> 32);
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v);
      check({tag, "/valid"}, 64'(out_valid), 64'(v));
      check({tag, "/res"}, 64'(out_res), 64'(e_res));
      check({tag, "/store"}, 64'(out_store), 64'(e_store));
      check({tag, "/rd"}, 64'(out_rd), 64'(e_rd));
      check({tag, "/ctl"}, {61'd0, out_wb, out_mem_rd, out_mem_wr}, {61'd0, e_wb, e_mrd, e_mwr});
   endtask

   task automatic check_zero(input string tag);
      check({tag, "/zero"}, {out_valid, out_res, out_store, out_rd, out_wb, out_mem_rd, out_mem_wr}, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] d, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] im, input logic src, input logic [2:0] ctl);
      alu_op = op; rs1 = r1; rs2 = r2; rd = d; rdata1 = a; rdata2 = b; imm = im;
      alu_src = src; {wb_en, mem_rd, mem_wr} = ctl;
   endtask

   task automatic clear_hazards();
      exmem_rd = '0; exmem_wb = 1'b0; exmem_res = '0;
      memwb_rd = '0; memwb_wb = 1'b0; memwb_res = '0;
   endtask

   task automatic predict();
      logic [XLEN-1:0] a, s;
      a = fwd_model(rs1, rdata1);
      s = fwd_model(rs2, rdata2);
      e_res = alu_model(alu_op, a, alu_src ? imm : s);
      e_store = s; e_rd = rd; e_wb = wb_en; e_mrd = mem_rd; e_mwr = mem_wr;
   endtask

   initial begin
      int nv;
      logic go;
`ifdef EXEC_UNIT_MUL_EN
      int lat;
`endif
      in_valid = 1'b0; flush = 1'b0;
      drive(4'd0, 5'd0, 5'd0, 5'd0, '0, '0, '0, 1'b0, 3'b000);
      clear_hazards();
      #2;
      check_zero("reset");
      check("reset_ready", 64'(in_ready), 64'd1);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check_out("idle", 1'b0);

      // ADD 5+7
      drive(4'd0, 5'd1, 5'd2, 5'd5, 32'd5, 32'd7, 32'd0, 1'b0, 3'b100);
      in_valid = 1'b1; predict(); tick(); in_valid = 1'b0;
      check_out("add", 1'b1);
      check("add_val", 64'(out_res), 64'd12);
      tick();
      check_out("add_hold", 1'b0);

      // forwarding hazards, back-to-back issues
      drive(4'd0, 5'd3, 5'd4, 5'd7, 32'd55, 32'd66, 32'd1, 1'b1, 3'b101);
      exmem_rd = 5'd3; exmem_wb = 1'b1; exmem_res = 32'd100;
      memwb_rd = 5'd3; memwb_wb = 1'b1; memwb_res = 32'd200;
      in_valid = 1'b1; predict(); tick();
      check_out("haz_ex", 1'b1);
      check("haz_ex_val", 64'(out_res), 64'd101);
      exmem_wb = 1'b0; predict(); tick();
      check("haz_wb_val", 64'(out_res), 64'd201);
      rs1 = 5'd0; predict(); tick();
      check("haz_r0_val", 64'(out_res), 64'd56);
      rs2 = 5'd3; exmem_wb = 1'b1; predict(); tick();
      check("haz_store", 64'(out_store), 64'd100);
      check_out("haz_store", 1'b1);
      clear_hazards();

      // SRA / SLT / SLTU boundaries
      drive(4'd7, 5'd1, 5'd2, 5'd3, 32'h8000_0000, 32'h21, 32'd0, 1'b0, 3'b010);
      predict(); tick();
      check("sra_val", 64'(out_res), 64'hC000_0000);
      drive(4'd8, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 3'b001);
      predict(); tick();
      check("slt_val", 64'(out_res), 64'd1);
      alu_op = 4'd9; predict(); tick();
      check("sltu_val", 64'(out_res), 64'd0);
      check_out("sltu", 1'b1);

      // unused opcodes, plus MUL codes when the multiplier is absent
      for (int op = 12; op < 16; op++) begin
         drive(4'(op), 5'd1, 5'd2, 5'd9, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0, 1'b0, 3'b111);
         predict(); tick();
         check_out("undef_op", 1'b1);
      end
`ifndef EXEC_UNIT_MUL_EN
      drive(4'd10, 5'd1, 5'd2, 5'd4, 32'd9, 32'd9, 32'd0, 1'b0, 3'b100);
      predict(); tick();
      check("nomul_lo", 64'(out_res), 64'd0);
      alu_op = 4'd11; predict(); tick();
      check("nomul_hi", 64'(out_res), 64'd0);
      check_out("nomul", 1'b1);
      check("nomul_ready", 64'(in_ready), 64'd1);
`endif
      in_valid = 1'b0; tick();
      check_out("gap", 1'b0);

      // flush wins over in_valid
      drive(4'd0, 5'd1, 5'd2, 5'd6, 32'd9, 32'd9, 32'd0, 1'b0, 3'b100);
      in_valid = 1'b1; flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      check_out("flush_idle", 1'b0);

      // randomized traffic
      for (int i = 0; i < 300; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         flush    = ($urandom_range(0, 9) == 0);
         drive(4'($urandom_range(0, 15)), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
               5'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
               1'($urandom), 3'($urandom));
`ifdef EXEC_UNIT_MUL_EN
         if (alu_op == 4'd10 || alu_op == 4'd11) alu_op = 4'd1;
`endif
         exmem_rd = 5'($urandom_range(0, 4)); exmem_wb = 1'($urandom); exmem_res = 32'($urandom);
         memwb_rd = 5'($urandom_range(0, 4)); memwb_wb = 1'($urandom); memwb_res = 32'($urandom);
         go = in_valid && !flush;
         if (go) predict();
         tick();
         check_out("rand", go);
         check("rand_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0; flush = 1'b0; clear_hazards();
      tick();
      check_out("rand_end", 1'b0);

`ifdef EXEC_UNIT_MUL_EN
      // MULHU 0xFFFFFFFF * 2
      drive(4'd11, 5'd1, 5'd2, 5'd12, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 3'b100);
      in_valid = 1'b1; predict(); tick(); in_valid = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         check("mulhu_busy", 64'(in_ready), 64'd0);
         check("mulhu_novalid", 64'(out_valid), 64'd0);
         tick();
      end
      check("mulhu_pre", 64'(out_valid), 64'd0);
      tick();
      check_out("mulhu", 1'b1);
      check("mulhu_val", 64'(out_res), 64'd1);
      check("mulhu_ready", 64'(in_ready), 64'd1);
      tick();
      check("mulhu_pulse", 64'(out_valid), 64'd0);

      // MUL low word, random operands, bounded wait
      drive(4'd10, 5'd1, 5'd2, 5'd13, 32'($urandom), 32'($urandom), 32'd0, 1'b0, 3'b110);
      in_valid = 1'b1; predict(); tick(); in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         tick();
         lat++;
      end
      check("mul_latency", 64'(lat), 64'd33);
      check_out("mul_lo", 1'b1);

      // flush at multiply cycle 10 with in_valid high
      drive(4'd10, 5'd1, 5'd2, 5'd14, 32'h1234, 32'h5678, 32'd0, 1'b0, 3'b111);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      repeat (9) tick();
      check("flush_busy", 64'(in_ready), 64'd0);
      drive(4'd0, 5'd1, 5'd2, 5'd15, 32'd1, 32'd1, 32'd0, 1'b0, 3'b100);
      in_valid = 1'b1; flush = 1'b1; tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_ready", 64'(in_ready), 64'd1);
      check_out("flush_mul", 1'b0);
      nv = 0;
      repeat (40) begin
         tick();
         if (out_valid) nv++;
      end
      check("flush_no_valid", 64'(nv), 64'd0);

      // reset mid-multiply
      drive(4'd10, 5'd1, 5'd2, 5'd16, 32'd77, 32'd3, 32'd0, 1'b0, 3'b100);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      repeat (5) tick();
`else
      // reset mid-operation with issues still arriving
      drive(4'd0, 5'd1, 5'd2, 5'd16, 32'd77, 32'd3, 32'd0, 1'b0, 3'b111);
      in_valid = 1'b1; predict(); tick();
      check_out("pre_reset", 1'b1);
`endif
      #2 rst_n = 1'b0;
      #1 check_zero("rst_async");
      check("rst_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b1;
      e_res = '0; e_store = '0; e_rd = '0; e_wb = 1'b0; e_mrd = 1'b0; e_mwr = 1'b0;
      nv = 0;
      repeat (40) begin
         tick();
         if (out_valid) nv++;
      end
      check("post_reset_no_valid", 64'(nv), 64'd0);
      check_out("post_reset", 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/exec_unit_pipe.md
EXEC_UNIT_PIPE -- requirements
Module: exec_unit_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 8..64, even).
REQ-002 SHALL have parameter FWD_EN_WB, default 1, meaning 1 enables MEM/WB forwarding and 0 forwards from EX/MEM only.
REQ-003 SHALL use one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-004 SHALL have the following ports:
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept
- flush  in  1  synchronous kill of in-flight and output state
- rs1, rs2, rd  in  5 each  ID/EX register indices
- rdata1, rdata2  in  XLEN each  ID/EX register-file data
- imm  in  XLEN  immediate
- alu_src  in  1  1 selects imm as operand B
- alu_op  in  4  operation code
- wb_en, mem_rd, mem_wr  in  1 each  control bits passed through
- exmem_rd  in  5  EX/MEM destination
- exmem_wb  in  1  EX/MEM write-back enable
- exmem_res  in  XLEN  EX/MEM result
- memwb_rd  in  5  MEM/WB destination
- memwb_wb  in  1  MEM/WB write-back enable
- memwb_res  in  XLEN  MEM/WB result
- out_valid  out  1  result valid, one-cycle pulse
- out_res  out  XLEN  registered result
- out_store  out  XLEN  registered forwarded rs2 data
- out_rd  out  5  registered rd
- out_wb, out_mem_rd, out_mem_wr  out  1 each  registered control bits

Function
REQ-005 Forwarding SHALL select per operand: EX/MEM if exmem_wb and exmem_rd==rs and rs!=0; else MEM/WB if FWD_EN_WB, memwb_wb, memwb_rd==rs and rs!=0; else rdata.
REQ-006 Operand A SHALL be forwarded rs1; operand B SHALL be imm when alu_src else forwarded rs2; out_store SHALL always be forwarded rs2.
REQ-007 alu_op SHALL decode as 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low XLEN), 11 MULHU (high XLEN, unsigned); codes 12-15 SHALL yield 0.
REQ-008 Shift amount SHALL be B[$clog2(XLEN)-1:0]; arithmetic SHALL wrap modulo 2^XLEN; SLT/SLTU SHALL produce 0 or 1 zero-extended.
REQ-009 An issue SHALL occur on a clk edge with in_valid && in_ready && !flush; operands, forwarded values and control bits SHALL be captured at that edge.
REQ-010 FSM states SHALL be IDLE, MUL and DONE:
- IDLE: single-cycle op issued -> out_valid=1 at the next edge, stay in IDLE; MUL/MULHU issued -> MUL with counter=0.
- MUL: one radix-2 shift-add step per cycle; after XLEN steps -> DONE.
- DONE: drive out_valid=1 for one cycle, then -> IDLE.
REQ-011 Latency SHALL be 1 cycle for ALU ops and XLEN+1 cycles for MUL/MULHU; in_ready SHALL equal (state==IDLE).
REQ-012 Back-to-back ALU issues SHALL give one result per cycle; out_valid SHALL be low in any cycle without a completing op.
REQ-013 flush SHALL force state to IDLE, clear out_valid and counter at the next edge, discard any partial product, and win over a simultaneous in_valid.
REQ-014 Registered outputs other than out_valid SHALL hold their last value when no op completes.

Reset
REQ-015 rst_n low SHALL immediately force state=IDLE, counter=0, out_valid=0, out_res=0, out_store=0, out_rd=0, out_wb=0, out_mem_rd=0, out_mem_wr=0, independent of clk.
REQ-016 Reset asserted mid-multiply SHALL abandon the operation, and no out_valid SHALL follow release.

Configuration
REQ-017 Macro EXEC_UNIT_MUL_EN defined SHALL compile in the multiplier, the MUL/DONE states and counter per REQ-010; undefined SHALL remove them, make codes 10/11 yield 0 with 1-cycle latency, and tie in_ready=1.

Verification
REQ-018 ADD: rdata1=5, rdata2=7, alu_src=0, no hazards -> out_res=12, out_valid one cycle after issue.
REQ-019 Hazard: rs1=3, exmem_rd=3/exmem_wb=1/exmem_res=100, memwb_rd=3/memwb_wb=1/memwb_res=200, imm=1, alu_src=1, ADD -> 101; with rs1=0 -> rdata1+1.
REQ-020 MULHU, XLEN=32: A=0xFFFFFFFF, B=2 -> out_res=1 after 33 cycles; in_ready low during cycles 1-32.
REQ-021 Flush at multiply cycle 10 with in_valid high -> no issue and no out_valid; in_ready=1 the next cycle.
REQ-022 SRA: A=0x80000000, B=0x21 -> 0xC0000000; SLT: A=-1, B=0 -> 1.
REQ-023 rst_n asserted mid-multiply -> all outputs 0 asynchronously; 40 cycles after release -> out_valid stays 0.
